// File: rtl/ram_mem.sv
// Data memory for the RV32 pipeline: byte-enabled stores, one-cycle registered
// word reads with write-first collision merging, pipeline hold and range flags.
module ram_mem #(
  parameter int          DEPTH     = 4096,
  parameter int          AW        = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_req_i,
  input  logic [31:0] mem_rd_addr_i,
  input  logic        mem_hold_i,
  input  logic        mem_wr_req_i,
  input  logic [31:0] mem_wr_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic [3:0]  mem_wr_be_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_rd_valid_o,
  output logic [1:0]  mem_rd_off_o,
  output logic        mem_rd_err_o,
  output logic        mem_wr_err_o
);

  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  logic [31:0]   mem_array [DEPTH];

  logic [31:0]   rd_rel;
  logic [31:0]   wr_rel;
  logic          rd_in_range;
  logic          wr_in_range;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic          collide;

  logic [31:0]   rd_raw_reg;
  logic [31:0]   byp_data_reg;
  logic [3:0]    byp_mask_reg;
  logic          data_en_reg;
  logic          rd_valid_reg;
  logic [1:0]    rd_off_reg;
  logic          rd_err_reg;
  logic          wr_err_reg;

  // Subtracting the base first makes addresses below BASE_ADDR wrap out of range.
  assign rd_rel      = mem_rd_addr_i - BASE_ADDR;
  assign wr_rel      = mem_wr_addr_i - BASE_ADDR;
  assign rd_in_range = {1'b0, rd_rel} < SPAN;
  assign wr_in_range = {1'b0, wr_rel} < SPAN;
  assign rd_idx      = rd_rel[AW+1:2];
  assign wr_idx      = wr_rel[AW+1:2];
  assign wr_en       = mem_wr_req_i & wr_in_range & ~rst;
  assign collide     = wr_en & (wr_idx == rd_idx);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_wr_be_i[k]) begin
          mem_array[wr_idx][8*k +: 8] <= mem_wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // Plain read-before-write port; colliding lanes are patched from the bypass regs.
  always_ff @(posedge clk) begin
    if (!mem_hold_i) begin
      rd_raw_reg <= mem_array[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_off_reg   <= 2'b00;
      rd_err_reg   <= 1'b0;
      data_en_reg  <= 1'b0;
      byp_mask_reg <= 4'b0000;
      byp_data_reg <= 32'h0;
      wr_err_reg   <= 1'b0;
    end else begin
      wr_err_reg <= mem_wr_req_i & ~wr_in_range;
      if (!mem_hold_i) begin
        rd_valid_reg <= mem_rd_req_i;
        rd_off_reg   <= mem_rd_addr_i[1:0];
        rd_err_reg   <= mem_rd_req_i & ~rd_in_range;
        data_en_reg  <= mem_rd_req_i & rd_in_range;
        byp_mask_reg <= collide ? mem_wr_be_i : 4'b0000;
        byp_data_reg <= mem_wr_data_i;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign mem_rd_data_o[8*gi +: 8] = !data_en_reg         ? 8'h00 :
                                        byp_mask_reg[gi]     ? byp_data_reg[8*gi +: 8] :
                                                               rd_raw_reg[8*gi +: 8];
    end
  endgenerate

  assign mem_rd_valid_o = rd_valid_reg;
  assign mem_rd_off_o   = rd_off_reg;
  assign mem_rd_err_o   = rd_err_reg;
  assign mem_wr_err_o   = wr_err_reg;

endmodule

// File: doc/ram_mem.md
Name: ram_mem

Overview:
- Data-memory responder for the RV32 pipeline.
- Serves word read requests issued by the decode stage (mem_rd_req/mem_rd_addr) and byte-enabled store writes issued by the execute stage.
- Synchronous single-port-per-direction RAM with a registered read path, write-first collision merging, pipeline hold and address-range error flags.
- Sits beside the register file; its read data is consumed by the execute/writeback load path.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of two, at least 4.
- AW, 12, word-index width, equal to log2(DEPTH).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- mem_rd_req_i  input  1  read request from decode.
- mem_rd_addr_i  input  32  read byte address.
- mem_hold_i  input  1  pipeline stall: freeze read output registers.
- mem_wr_req_i  input  1  store request from execute.
- mem_wr_addr_i  input  32  store byte address; bits [1:0] are ignored.
- mem_wr_data_i  input  32  store data, already lane-aligned.
- mem_wr_be_i  input  4  byte-lane enables; bit k writes byte k (bits [8k+7:8k]).
- mem_rd_data_o  output  32  read word.
- mem_rd_valid_o  output  1  mem_rd_data_o valid.
- mem_rd_off_o  output  2  registered mem_rd_addr_i[1:0], used for LB/LH/LBU/LHU extraction downstream.
- mem_rd_err_o  output  1  registered read address out of range.
- mem_wr_err_o  output  1  registered store address out of range.

Behaviour:
- Reset: the interface is one clock, synchronous active-high reset, named clk and rst. While rst=1 at a rising edge, all outputs become 0 on that edge and the edge's writes are suppressed. RAM contents are not cleared. A read accepted in the cycle reset asserts produces no valid.
- Address decode:
  - in_range = (addr - BASE_ADDR) < DEPTH*4, computed as 32-bit unsigned; anything else is out of range.
  - Word index = (addr - BASE_ADDR)[AW+1:2].
- Read latency is one cycle. On edge N, if mem_hold_i=0:
  - mem_rd_valid_o <= mem_rd_req_i.
  - mem_rd_off_o <= addr[1:0].
  - mem_rd_err_o <= req & !in_range.
  - mem_rd_data_o <= word, or 0 if out of range or no request.
- Hold: when mem_hold_i=1, all read output registers keep their values and no new read is sampled. Writes still commit during hold.
- Write: on an edge with mem_wr_req_i=1, in_range and rst=0, each byte lane with mem_wr_be_i[k]=1 is updated.
  - mem_wr_be_i=0 is a no-op, with no error.
  - mem_wr_err_o <= mem_wr_req_i & !in_range each edge; this is not affected by hold. An out-of-range write changes no memory.
- Collision (read and write to the same word on the same edge): write-first per byte. Enabled lanes return mem_wr_data_i; other lanes return the old RAM contents.
- Back-to-back: a read one cycle after a write to the same word returns the updated word. This follows from the RAM itself; no extra bypass is needed.
- No request queueing: one read per cycle max. A request with hold=1 is dropped, and the stalled pipeline must re-present it.
- Unaligned reads return the containing aligned word; mem_rd_off_o tells the consumer the byte position. Misalignment is not flagged.
- Address wrap: addresses below BASE_ADDR wrap to large unsigned values and are therefore out of range.

Test Plan:
1. Reset/basic: rst for 2 cycles, then write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10. Expect mem_rd_valid_o=1 one cycle after the request, data 32'hDEADBEEF, off=0, err=0. All outputs must be 0 during reset.
2. Byte enables and offset: preload 0x20=32'h11223344, write data 32'hAABBCCDD with be=4'b0100, then read 0x22. Expect data 32'h11BB3344, mem_rd_off_o=2.
3. Collision write-first: 0x30 holds 32'h00000000. On the same edge, write 32'hFFFF0000 with be=4'b1100 and read 0x30. Next cycle expect data 32'hFFFF0000.
4. Hold: issue a read of 0x10 and let it complete, then assert mem_hold_i for 3 cycles while presenting a read of 0x20 and a write to 0x20. Expect outputs frozen at the 0x10 result. After release, a re-presented read of 0x20 shows the written data.
5. Range errors (DEPTH=4096, BASE=0): read 0x4000. Expect valid=1, data=0, mem_rd_err_o=1. Write to 0x4000 with be=4'hF. Expect mem_wr_err_o=1 next cycle, and a subsequent read of 0x0 is unchanged (aliasing check).
6. Reset mid-operation: present a read and a write on the edge where rst=1. Expect valid=0 next cycle and the target word unchanged on a later read.
